// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction loader and the CPU decoder.
// Holds class codes, opcode/funct constants, FSM states and word builders.
package instr_encoder_loader_pkg;

   localparam logic [3:0] CLS_ADDU  = 4'd0;
   localparam logic [3:0] CLS_SUBU  = 4'd1;
   localparam logic [3:0] CLS_AND   = 4'd2;
   localparam logic [3:0] CLS_OR    = 4'd3;
   localparam logic [3:0] CLS_SLTU  = 4'd4;
   localparam logic [3:0] CLS_LW    = 4'd5;
   localparam logic [3:0] CLS_SW    = 4'd6;
   localparam logic [3:0] CLS_LUI   = 4'd7;
   localparam logic [3:0] CLS_BEQ   = 4'd8;
   localparam logic [3:0] CLS_ADDIU = 4'd9;
   localparam logic [3:0] CLS_J     = 4'd10;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   function automatic logic [31:0] enc_r(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [5:0] fn
   );
      return {OP_RTYPE, rs, rt, rd, 5'b0, fn};
   endfunction

   function automatic logic [31:0] enc_i(
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [15:0] imm
   );
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(
      input logic [25:0] tgt
   );
      return {OP_J, tgt};
   endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational symbolic-field to MIPS word encoder.
// Classes 11-15 raise the illegal flag and yield a zero word.
module instr_field_encoder
   import instr_encoder_loader_pkg::*;
(
   input  logic [3:0]  cls,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (cls)
         CLS_ADDU:  word = enc_r(rs, rt, rd, FN_ADDU);
         CLS_SUBU:  word = enc_r(rs, rt, rd, FN_SUBU);
         CLS_AND:   word = enc_r(rs, rt, rd, FN_AND);
         CLS_OR:    word = enc_r(rs, rt, rd, FN_OR);
         CLS_SLTU:  word = enc_r(rs, rt, rd, FN_SLTU);
         CLS_LW:    word = enc_i(OP_LW, rs, rt, imm);
         CLS_SW:    word = enc_i(OP_SW, rs, rt, imm);
         // LUI has no source register; rs is forced to zero
         CLS_LUI:   word = enc_i(OP_LUI, 5'd0, rt, imm);
         CLS_BEQ:   word = enc_i(OP_BEQ, rs, rt, imm);
         CLS_ADDIU: word = enc_i(OP_ADDIU, rs, rt, imm);
         CLS_J:     word = enc_j(target);
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads an encoded program into instruction memory, holding the CPU meanwhile.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of all written words.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_class,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
`ifdef LOADER_CHECKSUM_EN
   output logic [31:0]       checksum,
`endif
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              last_q, last_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       enc_word;
   logic              enc_illegal;

   instr_field_encoder u_enc (
      .cls     (in_class),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .imm     (in_imm),
      .target  (in_target),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (enc_illegal) begin
                  state_d = ST_ERR;
               end else begin
                  wdata_d = enc_word;
                  last_d  = in_last;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            count_d = count_q + 1'b1;
            // a last word at the top address is legal; only overflow errors
            if (last_q) begin
               state_d = ST_DONE;
            end else if (addr_q == ADDR_TOP) begin
               state_d = ST_ERR;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= ADDR_RST;
         wdata_q <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] cksum_q, cksum_d;

   always_comb begin
      cksum_d = cksum_q;
      if (state_q == ST_WRITE) begin
         cksum_d = cksum_q ^ wdata_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cksum_q <= '0;
      end else begin
         cksum_q <= cksum_d;
      end
   end

   assign checksum = cksum_q;
`endif

   assign in_ready   = (state_q == ST_IDLE);
   assign imem_we    = (state_q == ST_WRITE);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = (state_q != ST_DONE);
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERR);
   assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader at ADDR_W=8 and ADDR_W=2.
// Define LOADER_CHECKSUM_EN to also check the checksum output.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_class = '0;
   logic [4:0]  in_rs = '0;
   logic [4:0]  in_rt = '0;
   logic [4:0]  in_rd = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic        in_last = 1'b0;

   logic        rdy8, we8, hold8, done8, err8;
   logic [7:0]  addr8;
   logic [31:0] wd8;
   logic [8:0]  cnt8;
   logic        rdy2, we2, hold2, done2, err2;
   logic [1:0]  addr2;
   logic [31:0] wd2;
   logic [2:0]  cnt2;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] ck8, ck2;
`endif

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   instr_encoder_loader dut8 (
      .clk (clk), .reset (reset),
      .in_valid (in_valid), .in_ready (rdy8),
      .in_class (in_class), .in_rs (in_rs),
      .in_rt (in_rt), .in_rd (in_rd),
      .in_imm (in_imm), .in_target (in_target),
      .in_last (in_last), .imem_we (we8),
      .imem_addr (addr8), .imem_wdata (wd8),
      .cpu_hold (hold8), .done (done8),
      .error (err8),
`ifdef LOADER_CHECKSUM_EN
      .checksum (ck8),
`endif
      .count (cnt8)
   );

   instr_encoder_loader #(.ADDR_W(2)) dut2 (
      .clk (clk), .reset (reset),
      .in_valid (in_valid), .in_ready (rdy2),
      .in_class (in_class), .in_rs (in_rs),
      .in_rt (in_rt), .in_rd (in_rd),
      .in_imm (in_imm), .in_target (in_target),
      .in_last (in_last), .imem_we (we2),
      .imem_addr (addr2), .imem_wdata (wd2),
      .cpu_hold (hold2), .done (done2),
      .error (err2),
`ifdef LOADER_CHECKSUM_EN
      .checksum (ck2),
`endif
      .count (cnt2)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Present one instruction for a single edge; return at the next negedge.
   task automatic push(input logic [3:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [25:0] tg,
                       input logic last);
      in_class  = c;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_imm    = imm;
      in_target = tg;
      in_last   = last;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic exp_wr8(input string tag, input logic [7:0] a,
                          input logic [31:0] d);
      chk({tag, "_we"}, 64'(we8), 64'(1));
      chk({tag, "_addr"}, 64'(addr8), 64'(a));
      chk({tag, "_data"}, 64'(wd8), 64'(d));
      @(negedge clk);
   endtask

   initial begin
      // 1: reset values, then ADDU
      do_reset();
      chk("rst_we", 64'(we8), 64'(0));
      chk("rst_addr", 64'(addr8), 64'(0));
      chk("rst_wdata", 64'(wd8), 64'(0));
      chk("rst_hold", 64'(hold8), 64'(1));
      chk("rst_done", 64'(done8), 64'(0));
      chk("rst_err", 64'(err8), 64'(0));
      chk("rst_cnt", 64'(cnt8), 64'(0));
      chk("rst_rdy", 64'(rdy8), 64'(1));
      push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      chk("addu_rdy", 64'(rdy8), 64'(0));
      exp_wr8("addu", 8'd0, 32'h00221821);
      chk("s1_rdy", 64'(rdy8), 64'(1));
      chk("s1_addr", 64'(addr8), 64'(1));
      chk("s1_we", 64'(we8), 64'(0));
      chk("s1_hold_wd", 64'(wd8), 64'(32'h00221821));
      chk("s1_cnt", 64'(cnt8), 64'(1));

      // 2: LW and LUI (rs ignored)
      do_reset();
      push(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0);
      exp_wr8("lw", 8'd0, 32'h8FA80004);
      push(4'd7, 5'd7, 5'd1, 5'd0, 16'h1234, 26'h0, 1'b0);
      exp_wr8("lui", 8'd1, 32'h3C011234);

      // 3: BEQ then J with last
      do_reset();
      push(4'd8, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0, 1'b0);
      exp_wr8("beq", 8'd0, 32'h1085FFFF);
      push(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1);
      exp_wr8("j", 8'd1, 32'h08000010);
      chk("s3_done", 64'(done8), 64'(1));
      chk("s3_hold", 64'(hold8), 64'(0));
      chk("s3_cnt", 64'(cnt8), 64'(2));
      chk("s3_rdy", 64'(rdy8), 64'(0));

      // remaining classes
      do_reset();
      push(4'd1, 5'd1, 5'd2, 5'd3, 16'hAAAA, 26'h0, 1'b0);
      exp_wr8("subu", 8'd0, 32'h00221823);
      push(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      exp_wr8("and", 8'd1, 32'h00221824);
      push(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      exp_wr8("or", 8'd2, 32'h00221825);
      push(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      exp_wr8("sltu", 8'd3, 32'h0022182B);
      push(4'd6, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h0, 1'b0);
      exp_wr8("sw", 8'd4, 32'hAFA80004);
      push(4'd9, 5'd1, 5'd2, 5'd0, 16'h8000, 26'h3FFFFFF, 1'b1);
      exp_wr8("addiu", 8'd5, 32'h24228000);
      chk("cls_done", 64'(done8), 64'(1));

      // 4: illegal class after one word
      do_reset();
      push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      exp_wr8("pre_ill", 8'd0, 32'h00221821);
      push(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         chk("ill_state", 64'({we8, err8, hold8, rdy8, cnt8}),
             64'({1'b0, 1'b1, 1'b1, 1'b0, 9'd1}));
         @(negedge clk);
      end
      in_valid = 1'b0;

      // 5: ADDR_W=2 overflow
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(4'd0, 5'(i), 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
         chk("ovf_we", 64'(we2), 64'(1));
         chk("ovf_addr", 64'(addr2), 64'(i));
         @(negedge clk);
      end
      chk("ovf_err", 64'(err2), 64'(1));
      chk("ovf_rdy", 64'(rdy2), 64'(0));
      push(4'd0, 5'd9, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
      chk("ovf_nowe", 64'(we2), 64'(0));
      chk("ovf_cnt", 64'(cnt2), 64'(4));
      chk("ovf_hold", 64'(hold2), 64'(1));

      // 5b: last word at the top address
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(4'd0, 5'(i), 5'd0, 5'd0, 16'h0, 26'h0, 1'(i == 3));
         chk("top_we", 64'(we2), 64'(1));
         chk("top_addr", 64'(addr2), 64'(i));
         @(negedge clk);
      end
      chk("top_done", 64'(done2), 64'(1));
      chk("top_err", 64'(err2), 64'(0));
      chk("top_cnt", 64'(cnt2), 64'(4));

      // 6: reset during WRITE
      do_reset();
      push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      chk("mid_we_pre", 64'(we8), 64'(1));
      #1 reset = 1'b0;
      #1 chk("mid_we_async", 64'(we8), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_addr", 64'(addr8), 64'(0));
      chk("mid_cnt", 64'(cnt8), 64'(0));
      chk("mid_wd", 64'(wd8), 64'(0));

`ifdef LOADER_CHECKSUM_EN
      chk("ck_rst", 64'(ck8), 64'(0));
      push(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      @(negedge clk);
      push(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
      @(negedge clk);
      chk("ck_val", 64'(ck8), 64'(32'h00221800));
      repeat (3) @(negedge clk);
      chk("ck_stable", 64'(ck8), 64'(32'h00221800));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the CPU's instruction decoder: takes symbolic instruction fields over a valid/ready handshake and encodes them into 32-bit MIPS words. Writes the words sequentially into instruction memory through a write port. Holds the CPU in stall until the program is fully loaded. Sits between the testbench/host loader and the instruction-memory write side, ahead of the datapath.

Parameters:
ADDR_W, 8, word-address width of instruction memory; depth = 2**ADDR_W words
BASE_ADDR, 0, first word address written after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  host presents an instruction
in_ready  out  1  encoder accepts on in_valid && in_ready
in_class  in  4  0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLTU, 5 LW, 6 SW, 7 LUI, 8 BEQ, 9 ADDIU, 10 J; 11-15 illegal
in_rs  in  5  source register
in_rt  in  5  second source / I-type destination
in_rd  in  5  R-type destination
in_imm  in  16  I-type immediate/offset
in_target  in  26  J target field
in_last  in  1  marks final instruction of the program
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  encoded instruction
cpu_hold  out  1  stall CPU while loading
done  out  1  program loaded
error  out  1  sticky fault
count  out  ADDR_W+1  number of words written

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (asserted immediately, asynchronously): state IDLE; imem_we 0; imem_addr BASE_ADDR; imem_wdata 0; cpu_hold 1; done 0; error 0; count 0.
- States: IDLE, WRITE, DONE, ERR.
- in_ready = (state == IDLE), decoded combinationally from the state register.
- IDLE, on handshake with a legal class:
  - Register the encoded word into imem_wdata.
  - Latch in_last.
  - Go to WRITE.
- IDLE, on handshake with an illegal class (11-15): go to ERR, error=1, no write.
- WRITE: imem_we=1 for exactly one cycle at the current imem_addr; count+1.
  - Latched last=1: go to DONE.
  - Else, imem_addr == 2**ADDR_W-1: go to ERR (memory full, no wrap).
  - Else: imem_addr+1, go to IDLE.
- Latency and throughput: the write strobe occurs in the cycle after acceptance; maximum throughput is 1 instruction per 2 cycles.
- DONE: cpu_hold=0, done=1, in_ready=0. Stays in DONE until reset.
- ERR: cpu_hold=1, error=1, in_ready=0, imem_we=0. Stays in ERR until reset.
- Encoding: R-type = {6'b0, rs, rt, rd, 5'b0, funct}.
  - funct values: ADDU 100001, SUBU 100011, AND 100100, OR 100101, SLTU 101011.
- Encoding: I-type = {op, rs, rt, imm}.
  - op values: LW 100011, SW 101011, BEQ 000100, ADDIU 001001.
  - LUI uses op 001111 and forces rs=0.
- Encoding: J = {000010, target}.
- Fields irrelevant to a class are ignored, and unused fields in the word are zero.
- Reset mid-WRITE: the strobe is dropped immediately and all outputs return to reset values.
- Writing the final word at the top address with last=1 is legal and ends in DONE, not ERR.
- imem_addr and imem_wdata hold their values outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], reset 0.
  - In each WRITE cycle, checksum <= checksum ^ imem_wdata.
  - Stable in DONE/ERR.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - in_class localparam codes;
  - opcode and funct constants (shared with the decoder);
  - state encoding.
- One sub-module is natural: instr_field_encoder.
  - Purely combinational.
  - Inputs: class plus fields. Outputs: word[31:0] and illegal flag.
- The top module holds the FSM, address counter, count and output registers.

Test Plan:
1. Reset, then ADDU rs=1 rt=2 rd=3 with last=0:
   - one cycle later imem_we=1, addr 0, wdata 0x00221821;
   - next cycle in_ready=1, addr 1.
2. LW rt=8 rs=29 imm=0x0004, then LUI rt=1 imm=0x1234 with rs=7 (ignored):
   - words 0x8FA80004 then 0x3C011234 at addresses 0 and 1.
3. BEQ rs=4 rt=5 imm=0xFFFF, then J target=0x0000010 with last=1:
   - words 0x1085FFFF and 0x08000010;
   - then done=1, cpu_hold=0, count=2, in_ready=0.
4. Illegal class 12 after one valid word:
   - error=1, no further imem_we, count stays 1, cpu_hold=1, persists for 20 cycles.
5. ADDR_W=2: five instructions with last=0:
   - 4 writes at addresses 0-3, then ERR.
   - Repeat with last=1 on the 4th instruction: DONE, no error.
6. Assert reset in the WRITE cycle:
   - imem_we falls asynchronously;
   - after release, addr=BASE_ADDR and count=0.
   - With LOADER_CHECKSUM_EN and the words from scenario 1 plus 0x00000021: checksum = 0x00221800.
